fetch_ifid: RTL and testbench
=============================

FETCH_IFID -- requirements
Module: fetch_ifid

Interface
REQ-001 SHALL have parameter N, default 64, giving PC and address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on clk rising edge).
REQ-004 SHALL have port StallF  input  1  hazard stall: hold PC and IF/ID register.
REQ-005 SHALL have port FlushD  input  1  squash the instruction entering IF/ID.
REQ-006 SHALL have port PCSrc  input  1  taken-branch redirect (CBZ taken).
REQ-007 SHALL have port PCBranch  input  N  branch target address.
REQ-008 SHALL have port imem_addr  output  N  current fetch address (PC).
REQ-009 SHALL have port imem_data  input  32  instruction word returned for imem_addr.
REQ-010 SHALL have port imem_ready  input  1  imem_data valid this cycle.
REQ-011 SHALL have port instr_D  output  32  registered instruction, decode stage.
REQ-012 SHALL have port pc_D  output  N  registered PC of instr_D.
REQ-013 SHALL have port valid_D  output  1  instr_D holds a real instruction.
REQ-014 SHALL have port op_D  output  11  instr_D[31:21], the opcode field consumed by maindec.
REQ-015 SHALL have port bubble_cnt  output  32  count of bubbles inserted into IF/ID.

Function
REQ-016 SHALL drive imem_addr combinationally from the PC register.
REQ-017 SHALL drive op_D combinationally as instr_D[31:21]; no other logic.
REQ-018 SHALL update PC and IF/ID on each rising edge with priority: reset > PCSrc > StallF > FlushD > imem_ready.
REQ-019 PCSrc=1: PC <= {PCBranch[N-1:2],2'b00}; IF/ID loads bubble (instr_D=0, pc_D=0, valid_D=0), regardless of StallF and imem_ready.
REQ-020 StallF=1, PCSrc=0: PC, instr_D, pc_D, valid_D all hold; bubble_cnt holds.
REQ-021 FlushD=1, PCSrc=0, StallF=0: IF/ID loads bubble; PC <= PC+4 if imem_ready=1, else holds.
REQ-022 imem_ready=0, no higher-priority event: PC holds; IF/ID loads bubble.
REQ-023 Normal (imem_ready=1, no other event): instr_D <= imem_data, pc_D <= PC, valid_D <= 1, PC <= PC+4.
REQ-024 PC+4 SHALL wrap modulo 2^N (all-ones-minus-3 + 4 = 0).
REQ-025 Bubble instr_D=0 SHALL give op_D=11'b0, an opcode maindec decodes to all-zero controls.
REQ-026 bubble_cnt SHALL increment by 1 on every edge at which IF/ID loads a bubble (REQ-019/021/022), saturating at 32'hFFFF_FFFF.
REQ-027 Fetch latency: instruction at address A presented with imem_ready=1 appears on instr_D one cycle later.
REQ-028 Branch penalty: exactly one bubble per taken branch; the wrong-path instruction in IF is discarded.

Reset
REQ-029 While reset=0 at a rising edge: PC <= 0, instr_D <= 0, pc_D <= 0, valid_D <= 0, bubble_cnt <= 0; all other inputs ignored.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL take effect at that edge with no residual state.
REQ-031 First fetch after reset release SHALL be address 0; reset cycles SHALL not count as bubbles.

Verification
REQ-032 reset=0 two cycles, then reset=1, imem_ready=1, imem_data=32'hF84000A1 -> after 1 edge: instr_D=F84000A1, op_D=11'b11111000010 (LDUR), pc_D=0, valid_D=1, imem_addr=4.
REQ-033 PC=8, PCSrc=1, PCBranch=64'h43 -> next edge: imem_addr=64'h40, valid_D=0, op_D=0, bubble_cnt+1; next edge fetches 0x40.
REQ-034 PC=12, StallF=1 for 3 cycles with imem_ready toggling -> PC=12, instr_D/pc_D/valid_D unchanged, bubble_cnt unchanged; release -> fetch resumes at 12.
REQ-035 imem_ready=0 for 2 cycles at PC=16 -> 2 bubbles (valid_D=0, bubble_cnt+2), PC stays 16; ready=1 -> instr at 16 loaded, PC=20.
REQ-036 PC=64'hFFFF_FFFF_FFFF_FFFC, normal fetch -> PC=0, pc_D=FFFF_FFFF_FFFF_FFFC.
REQ-037 PCSrc=1 and StallF=1 and FlushD=1 same edge -> PC=PCBranch aligned, bubble loaded; reset=0 on following edge -> all outputs zero, bubble_cnt=0.

Source files
------------

// File: rtl/fetch_ifid.sv
// Fetch stage PC register plus the IF/ID pipeline register, with stall,
// flush, taken-branch redirect and a saturating count of inserted bubbles.
module fetch_ifid #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         FlushD,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_data,
    input  logic         imem_ready,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic [10:0]  op_D,
    output logic [31:0]  bubble_cnt
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic [N-1:0] r_pc_d;
    logic         r_valid;
    logic [31:0]  r_bubble_cnt;

    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_branch_pc;
    logic         w_bubble;

    // A stall freezes everything, so a redirect is the only way a stalled
    // edge can still load a bubble.
    always_comb begin
        w_pc_plus4  = r_pc + PC_STEP;
        w_branch_pc = {PCBranch[N-1:2], 2'b00};
        w_bubble    = PCSrc | (~StallF & (FlushD | ~imem_ready));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_pc_d  <= '0;
            r_valid <= 1'b0;
        end else if (PCSrc) begin
            r_pc    <= w_branch_pc;
            r_instr <= '0;
            r_pc_d  <= '0;
            r_valid <= 1'b0;
        end else if (StallF) begin
            r_pc    <= r_pc;
            r_instr <= r_instr;
            r_pc_d  <= r_pc_d;
            r_valid <= r_valid;
        end else if (FlushD || !imem_ready) begin
            // A flushed fetch still advances when memory answered this cycle.
            if (imem_ready) begin
                r_pc <= w_pc_plus4;
            end
            r_instr <= '0;
            r_pc_d  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_pc_plus4;
            r_instr <= imem_data;
            r_pc_d  <= r_pc;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign imem_addr  = r_pc;
    assign instr_D    = r_instr;
    assign pc_D       = r_pc_d;
    assign valid_D    = r_valid;
    assign op_D       = r_instr[31:21];
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_fetch_ifid.sv
// Randomized and directed bench for fetch_ifid: a reference model pushes the
// expected post-edge state into a queue; a monitor pops and compares each cycle.
module tb_fetch_ifid;
  localparam int N = 64;
  localparam int W = 32 + N + 1 + 32 + N;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         stall_f;
  logic         flush_d;
  logic         pc_src;
  logic [N-1:0] pc_branch;
  logic [N-1:0] imem_addr;
  logic [31:0]  imem_data;
  logic         imem_ready;
  logic [31:0]  instr_d;
  logic [N-1:0] pc_d;
  logic         valid_d;
  logic [10:0]  op_d;
  logic [31:0]  bubble_cnt;

  fetch_ifid #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (stall_f),
    .FlushD     (flush_d),
    .PCSrc      (pc_src),
    .PCBranch   (pc_branch),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .instr_D    (instr_d),
    .pc_D       (pc_d),
    .valid_D    (valid_d),
    .op_D       (op_d),
    .bubble_cnt (bubble_cnt)
  );

  // Instruction memory: a fixed word per address, with an LDUR at address 0.
  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    if (a == '0) return 32'hF840_00A1;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state after each edge.
  logic [N-1:0] m_pc;
  logic [31:0]  m_instr;
  logic [N-1:0] m_pcd;
  logic         m_valid;
  logic [31:0]  m_cnt;

  // ---------------- driver ----------------
  task automatic step(input logic rst_n, input logic st, input logic fl, input logic br,
                      input logic [N-1:0] tgt, input logic rdy);
    logic bubble;
    @(negedge clk);
    reset      = rst_n;
    stall_f    = st;
    flush_d    = fl;
    pc_src     = br;
    pc_branch  = tgt;
    imem_ready = rdy;
    bubble     = 1'b0;
    if (!rst_n) begin
      m_pc = '0; m_instr = '0; m_pcd = '0; m_valid = 1'b0; m_cnt = '0;
    end else begin
      if (br) begin
        m_pc   = tgt & ~(N'(3));
        bubble = 1'b1;
      end else if (!st) begin
        if (fl || !rdy) begin
          bubble = 1'b1;
        end else begin
          m_instr = mem_word(m_pc);
          m_pcd   = m_pc;
          m_valid = 1'b1;
        end
        if (rdy) m_pc = m_pc + 4;
      end
      if (bubble) begin
        m_instr = '0; m_pcd = '0; m_valid = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    exp_q.push_back({m_instr, m_pcd, m_valid, m_cnt, m_pc});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_imem_addr",  imem_addr,  e[N-1:0]);
      check("sb_bubble_cnt", {32'd0, bubble_cnt}, {32'd0, e[N+31:N]});
      check("sb_valid_D",    {63'd0, valid_d},    {63'd0, e[N+32]});
      check("sb_pc_D",       pc_d,       e[2*N+32:N+33]);
      check("sb_instr_D",    {32'd0, instr_d},    {32'd0, e[W-1:W-32]});
      check("sb_op_D",       {53'd0, op_d},       {53'd0, e[W-1:W-11]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pc_src = 1'b0;
    pc_branch = '0; imem_ready = 1'b0;

    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, '0, 0);
    #1;
    check("rst_instr_D", {32'd0, instr_d}, 64'd0);
    check("rst_bubble_cnt", {32'd0, bubble_cnt}, 64'd0);

    // First fetch after reset: LDUR at address 0
    step(1, 0, 0, 0, '0, 1);
    #1;
    check("ldur_instr_D", {32'd0, instr_d}, 64'hF840_00A1);
    check("ldur_op_D", {53'd0, op_d}, {53'd0, 11'b11111000010});
    check("ldur_pc_D", pc_d, 64'd0);
    check("ldur_valid_D", {63'd0, valid_d}, 64'd1);
    check("ldur_imem_addr", imem_addr, 64'd4);

    // Taken branch from PC=8 to 0x43 -> aligned 0x40, one bubble
    step(1, 0, 0, 0, '0, 1);
    step(1, 0, 0, 1, 64'h43, 1);
    #1;
    check("br_imem_addr", imem_addr, 64'h40);
    check("br_valid_D", {63'd0, valid_d}, 64'd0);
    check("br_op_D", {53'd0, op_d}, 64'd0);
    check("br_bubble_cnt", {32'd0, bubble_cnt}, 64'd1);
    step(1, 0, 0, 0, '0, 1);
    #1;
    check("br_fetch_pc_D", pc_d, 64'h40);

    // Stall at PC=12 for 3 cycles with imem_ready toggling
    step(1, 0, 0, 1, 64'h8, 0);
    step(1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, '0, logic'(i[0]));
      #1;
      check("stall_imem_addr", imem_addr, 64'd12);
      check("stall_pc_D", pc_d, 64'd8);
      check("stall_valid_D", {63'd0, valid_d}, 64'd1);
      check("stall_bubble_cnt", {32'd0, bubble_cnt}, 64'd2);
    end
    step(1, 0, 0, 0, '0, 1);
    #1;
    check("unstall_pc_D", pc_d, 64'd12);

    // imem not ready for 2 cycles at PC=16
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    #1;
    check("nrdy_imem_addr", imem_addr, 64'd16);
    check("nrdy_valid_D", {63'd0, valid_d}, 64'd0);
    check("nrdy_bubble_cnt", {32'd0, bubble_cnt}, 64'd4);
    step(1, 0, 0, 0, '0, 1);
    #1;
    check("rdy_pc_D", pc_d, 64'd16);
    check("rdy_imem_addr", imem_addr, 64'd20);

    // PC wrap at the top of the address space
    step(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    step(1, 0, 0, 0, '0, 1);
    #1;
    check("wrap_imem_addr", imem_addr, 64'd0);
    check("wrap_pc_D", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);

    // Redirect beats stall and flush; reset on the next edge clears all
    step(1, 1, 1, 1, 64'h1237, 1);
    #1;
    check("prio_imem_addr", imem_addr, 64'h1234);
    check("prio_valid_D", {63'd0, valid_d}, 64'd0);
    check("prio_bubble_cnt", {32'd0, bubble_cnt}, 64'd6);
    step(0, 1, 0, 1, 64'h80, 1);
    #1;
    check("rst2_imem_addr", imem_addr, 64'd0);
    check("rst2_pc_D", pc_d, 64'd0);
    check("rst2_bubble_cnt", {32'd0, bubble_cnt}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] tgt;
      tgt = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) tgt = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           tgt,
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    check("sb_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
